// File: rtl/vera_mem_pkg.sv
// Shared constants for the sprite attribute memory: clear-FSM encodings and default geometry.
package vera_mem_pkg;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_BYTE_W = 8;
endpackage

// File: rtl/sprite_attr_mem_if.sv
// Write/read/clear bus between the CPU-side write path, the sprite fetch and the attribute memory.
interface sprite_attr_mem_if
   import vera_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BYTE_W = DEF_BYTE_W,
   parameter int ADDR_W = 8
);
   logic                       clear_req_i;
   logic                       wr_en_i;
   logic [DATA_W/BYTE_W-1:0]   wr_ben_i;
   logic [ADDR_W-1:0]          wr_addr_i;
   logic [DATA_W-1:0]          wr_data_i;
   logic                       wr_ready_o;
   logic                       rd_en_i;
   logic [ADDR_W-1:0]          rd_addr_i;
   logic [DATA_W-1:0]          rd_data_o;
   logic                       rd_valid_o;
   logic                       busy_o;
   logic                       clear_done_o;

   modport master (
      output clear_req_i, wr_en_i, wr_ben_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
      input  wr_ready_o, rd_data_o, rd_valid_o, busy_o, clear_done_o
   );

   modport slave (
      input  clear_req_i, wr_en_i, wr_ben_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
      output wr_ready_o, rd_data_o, rd_valid_o, busy_o, clear_done_o
   );
endinterface

// File: rtl/bram_be_1r1w.sv
// Plain storage array: byte-enabled write port, registered read port; no reset, no bypass.
module bram_be_1r1w
   import vera_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BYTE_W = DEF_BYTE_W,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      i_we,
   input  logic [DATA_W/BYTE_W-1:0]  i_ben,
   input  logic [ADDR_W-1:0]         i_waddr,
   input  logic [DATA_W-1:0]         i_wdata,
   input  logic                      i_re,
   input  logic [ADDR_W-1:0]         i_raddr,
   output logic [DATA_W-1:0]         o_rdata
);
   localparam int NB = DATA_W / BYTE_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (i_we && i_ben[b]) begin
            r_mem[i_waddr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
         end
      end
   end

   // Read returns the pre-write word on an address collision; merging is the caller's job.
   always_ff @(posedge clk) begin
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end
endmodule

// File: rtl/sprite_attr_mem.sv
// Sprite attribute memory: clear-sweep FSM, read-during-write bypass and 1/2-cycle read pipeline.
// state   | meaning
// IDLE    | normal operation, writes accepted
// CLEAR   | zeroing one word per cycle, writes dropped, reads return 0
module sprite_attr_mem
   import vera_mem_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BYTE_W     = DEF_BYTE_W,
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int RD_LATENCY = 1,
   parameter int BYPASS     = 1,
   parameter int INIT_CLEAR = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   sprite_attr_mem_if.slave  bus
);
   localparam int NB = DATA_W / BYTE_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [0:0]         r_state;
   logic [ADDR_W-1:0]  r_sweep;
   logic               r_done;
   logic               w_busy;
   logic               w_wr_fire;
   logic               w_byp_hit;
   logic [DATA_W-1:0]  w_ben_mask;
   logic [DATA_W-1:0]  w_ram_q;
   logic [DATA_W-1:0]  w_merged;
   logic               r_v1;
   logic               r_zero1;
   logic [DATA_W-1:0]  r_mask1;
   logic [DATA_W-1:0]  r_bdata1;

   assign w_busy    = (r_state == ST_CLEAR);
   assign w_wr_fire = bus.wr_en_i && !w_busy;
   assign w_byp_hit = (BYPASS != 0) && w_wr_fire && bus.rd_en_i
                      && (bus.rd_addr_i == bus.wr_addr_i);

   always_comb begin
      w_ben_mask = '0;
      for (int b = 0; b < NB; b++) begin
         w_ben_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{bus.wr_ben_i[b]}};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
         r_sweep <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.clear_req_i) begin
                  r_state <= ST_CLEAR;
                  r_sweep <= '0;
               end
            end
            default: begin
               r_sweep <= r_sweep + 1'b1;
               if (r_sweep == LAST_ADDR) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
         endcase
      end
   end

   // The sweep borrows the single write port while busy.
   bram_be_1r1w #(
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk_i),
      .i_we    (w_busy || w_wr_fire),
      .i_ben   (w_busy ? {NB{1'b1}} : bus.wr_ben_i),
      .i_waddr (w_busy ? r_sweep : bus.wr_addr_i),
      .i_wdata (w_busy ? {DATA_W{1'b0}} : bus.wr_data_i),
      .i_re    (bus.rd_en_i),
      .i_raddr (bus.rd_addr_i),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_v1     <= 1'b0;
         r_zero1  <= 1'b0;
         r_mask1  <= '0;
         r_bdata1 <= '0;
      end else begin
         r_v1 <= bus.rd_en_i;
         if (bus.rd_en_i) begin
            r_zero1  <= w_busy;
            r_mask1  <= w_byp_hit ? w_ben_mask : '0;
            r_bdata1 <= bus.wr_data_i;
         end
      end
   end

   assign w_merged = r_zero1 ? '0 : ((w_ram_q & ~r_mask1) | (r_bdata1 & r_mask1));

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic              r_v2;
         logic [DATA_W-1:0] r_data2;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_v2    <= 1'b0;
               r_data2 <= '0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) begin
                  r_data2 <= w_merged;
               end
            end
         end
         assign bus.rd_valid_o = r_v2;
         assign bus.rd_data_o  = r_data2;
      end else begin : g_lat1
         // Stage-1 registers only move on a read, so the merge holds; mask it to 0 until the first read.
         logic r_seen;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_seen <= 1'b0;
            end else if (bus.rd_en_i) begin
               r_seen <= 1'b1;
            end
         end
         assign bus.rd_valid_o = r_v1;
         assign bus.rd_data_o  = r_seen ? w_merged : '0;
      end
   endgenerate

   assign bus.busy_o       = w_busy;
   assign bus.wr_ready_o   = !w_busy;
   assign bus.clear_done_o = r_done;
endmodule

// File: tb/tb_sprite_attr_mem.sv
// Directed bench for sprite_attr_mem: reset sweep, byte enables, bypass, clear request, reset abort, streaming.
module tb_sprite_attr_mem;
   localparam int RDL = 1;
   localparam int BYP = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sprite_attr_mem_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(8)) bus ();

   sprite_attr_mem #(
      .DATA_W(32), .BYTE_W(8), .DEPTH(256),
      .RD_LATENCY(RDL), .BYPASS(BYP), .INIT_CLEAR(1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] ben);
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = a;
      bus.wr_data_i = d;
      bus.wr_ben_i  = ben;
      @(negedge clk);
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic v);
      bus.rd_en_i   = 1'b1;
      bus.rd_addr_i = a;
      @(negedge clk);
      bus.rd_en_i   = 1'b0;
      repeat (RDL - 1) @(negedge clk);
      d = bus.rd_data_o;
      v = bus.rd_valid_o;
   endtask

   // Called at the negedge where rst was just released (or a sweep was just requested).
   task automatic count_sweep(output int nbusy, output int ndone);
      nbusy = 0;
      ndone = 0;
      for (int k = 0; k < 300; k++) begin
         if (bus.busy_o === 1'b1) nbusy++;
         if (bus.clear_done_o === 1'b1) ndone++;
         @(negedge clk);
      end
   endtask

   logic [31:0] d;
   logic        v;
   int          nb, nd, nlow;
   logic [31:0] cap;
   logic        obs_v [14];
   logic [31:0] obs_d [14];

   initial begin
      bus.clear_req_i = 1'b0;
      bus.wr_en_i     = 1'b0;
      bus.wr_ben_i    = '0;
      bus.wr_addr_i   = '0;
      bus.wr_data_i   = '0;
      bus.rd_en_i     = 1'b0;
      bus.rd_addr_i   = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy",     32'(bus.busy_o),       32'd1);
      chk("rst_wr_ready", 32'(bus.wr_ready_o),   32'd0);
      chk("rst_valid",    32'(bus.rd_valid_o),   32'd0);
      chk("rst_data",     bus.rd_data_o,         32'd0);
      chk("rst_done",     32'(bus.clear_done_o), 32'd0);

      rst = 1'b0;
      count_sweep(nb, nd);
      chk("init_busy_cycles", 32'(nb), 32'd256);
      chk("init_done_pulses", 32'(nd), 32'd1);
      chk("init_busy_after",  32'(bus.busy_o), 32'd0);

      rd(8'd0, d, v);   chk("init_rd0", d, 32'h0);   chk("init_rd0_v", 32'(v), 32'd1);
      rd(8'd128, d, v); chk("init_rd128", d, 32'h0);
      rd(8'd255, d, v); chk("init_rd255", d, 32'h0);

      wr(8'd5, 32'hAABBCCDD, 4'b1111);
      wr(8'd5, 32'h11223344, 4'b0101);
      bus.rd_en_i = 1'b1; bus.rd_addr_i = 8'd5;
      @(negedge clk);
      bus.rd_en_i = 1'b0;
      chk("ben_valid_t1", 32'(bus.rd_valid_o), (RDL == 1) ? 32'd1 : 32'd0);
      repeat (RDL - 1) @(negedge clk);
      chk("ben_merge", bus.rd_data_o, 32'hAA22CC44);
      chk("ben_valid", 32'(bus.rd_valid_o), 32'd1);
      @(negedge clk);
      chk("hold_valid_low", 32'(bus.rd_valid_o), 32'd0);
      chk("hold_data",      bus.rd_data_o, 32'hAA22CC44);
      wr(8'd5, 32'h00000000, 4'b0000);
      rd(8'd5, d, v);   chk("ben_zero_noop", d, 32'hAA22CC44);

      wr(8'd9, 32'h12345678, 4'b1111);
      bus.wr_en_i = 1'b1; bus.wr_addr_i = 8'd9; bus.wr_data_i = 32'hFFFFFFFF; bus.wr_ben_i = 4'b0011;
      bus.rd_en_i = 1'b1; bus.rd_addr_i = 8'd9;
      @(negedge clk);
      bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
      repeat (RDL - 1) @(negedge clk);
      chk("bypass_same_cycle", bus.rd_data_o, (BYP != 0) ? 32'h1234FFFF : 32'h12345678);
      rd(8'd9, d, v);   chk("bypass_followup", d, 32'h1234FFFF);

      bus.wr_en_i = 1'b1; bus.wr_addr_i = 8'd10; bus.wr_data_i = 32'hCAFEF00D; bus.wr_ben_i = 4'b1111;
      bus.rd_en_i = 1'b1; bus.rd_addr_i = 8'd9;
      @(negedge clk);
      bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
      repeat (RDL - 1) @(negedge clk);
      chk("diff_addr_rd", bus.rd_data_o, 32'h1234FFFF);
      rd(8'd10, d, v);  chk("diff_addr_wr", d, 32'hCAFEF00D);

      for (int i = 0; i < 256; i++) wr(8'(i), 32'hDEADBEEF, 4'b1111);
      rd(8'd200, d, v); chk("fill_check", d, 32'hDEADBEEF);

      nlow = 0; nd = 0; cap = 32'hFFFFFFFF;
      for (int k = 0; k < 300; k++) begin
         if (bus.wr_ready_o === 1'b0) nlow++;
         if (bus.clear_done_o === 1'b1) nd++;
         if (k == 50 + RDL) cap = bus.rd_data_o;
         bus.clear_req_i = (k == 0) || (k == 120);
         bus.wr_en_i     = (k == 50);
         bus.wr_addr_i   = 8'd3;
         bus.wr_data_i   = 32'h1;
         bus.wr_ben_i    = 4'b1111;
         bus.rd_en_i     = (k == 50);
         bus.rd_addr_i   = 8'd100;
         @(negedge clk);
      end
      bus.clear_req_i = 1'b0; bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
      chk("clr_ready_low_cycles", 32'(nlow), 32'd256);
      chk("clr_done_pulses",      32'(nd),   32'd1);
      chk("clr_rd_during_sweep",  cap,       32'h0);
      rd(8'd3, d, v);   chk("clr_dropped_write", d, 32'h0);
      rd(8'd255, d, v); chk("clr_last_word", d, 32'h0);

      bus.clear_req_i = 1'b1;
      @(negedge clk);
      bus.clear_req_i = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rst_busy", 32'(bus.busy_o),       32'd1);
      chk("abort_rst_done", 32'(bus.clear_done_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      count_sweep(nb, nd);
      chk("abort_busy_cycles", 32'(nb), 32'd256);
      chk("abort_done_pulses", 32'(nd), 32'd1);

      for (int i = 0; i < 10; i++) wr(8'(i), 32'(i), 4'b1111);
      for (int j = 0; j < 14; j++) begin
         obs_v[j] = bus.rd_valid_o;
         obs_d[j] = bus.rd_data_o;
         bus.rd_en_i   = (j < 10);
         bus.rd_addr_i = 8'(j);
         @(negedge clk);
      end
      bus.rd_en_i = 1'b0;
      for (int j = 0; j < 14; j++) begin
         chk($sformatf("stream_valid[%0d]", j), 32'(obs_v[j]),
             (j >= RDL && j < RDL + 10) ? 32'd1 : 32'd0);
         if (j >= RDL && j < RDL + 10) chk($sformatf("stream_data[%0d]", j), obs_d[j], 32'(j - RDL));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sprite_attr_mem.md
Name: sprite_attr_mem

Overview:
Parametrised single-clock 1R1W attribute memory with per-byte write enables. It is the successor to the fixed 256x32 sprite attribute RAM and adds three things: a hardware clear engine (runs after reset and on request), optional read-during-write bypass, and selectable read latency. It sits between the CPU-side attribute write path and the sprite engine's attribute fetch.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, byte-enable granularity in bits
DEPTH, 256, number of words; power of two, at least 4
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
RD_LATENCY, 1, read latency: 1 = RAM output, 2 = extra output register
BYPASS, 1, 1 = a same-cycle same-address read returns the newly written bytes
INIT_CLEAR, 1, 1 = run the clear sweep when reset deasserts

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
clear_req_i  in  1  single-cycle request to zero the whole memory
wr_en_i  in  1  write strobe
wr_ben_i  in  DATA_W/BYTE_W  byte enables; bit n covers bits [n*BYTE_W +: BYTE_W]
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  write data
wr_ready_o  out  1  write accepted this cycle; equals !busy_o
rd_en_i  in  1  read strobe
rd_addr_i  in  ADDR_W  read address
rd_data_o  out  DATA_W  read data
rd_valid_o  out  1  rd_data_o is valid this cycle
busy_o  out  1  clear sweep in progress
clear_done_o  out  1  one-cycle pulse when a sweep completes

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high on rst_i.
- Reset values: rd_data_o=0, rd_valid_o=0, clear_done_o=0, read pipeline flushed, sweep address=0.
  - busy_o resets to 1 when INIT_CLEAR=1, else 0.
  - RAM contents are not reset directly; they are zeroed only by the sweep.
- Clear state machine has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clear_req_i, or on the first edge after reset when INIT_CLEAR=1.
  - In CLEAR: one word is zeroed per cycle, from address 0 up to DEPTH-1.
  - After address DEPTH-1 is written: next cycle is IDLE, busy_o=0, clear_done_o=1 for exactly one cycle.
  - A sweep takes exactly DEPTH cycles.
  - clear_req_i while in CLEAR is ignored; there is no restart.
  - rst_i asserted mid-sweep aborts the sweep; with INIT_CLEAR=1 it restarts from address 0 after reset.
- Writes:
  - A write commits at the clock edge when wr_en_i && wr_ready_o; only the enabled bytes change.
  - wr_en_i while busy_o=1 is dropped silently. The caller must hold or retry.
  - wr_ben_i = 0 is a legal no-op.
- Reads:
  - Accepted whenever rd_en_i=1, including during CLEAR.
  - RD_LATENCY=1: rd_valid_o and rd_data_o appear on the cycle after rd_en_i.
  - RD_LATENCY=2: they appear two cycles after rd_en_i.
  - Back-to-back reads are allowed every cycle.
  - rd_data_o holds its last value when rd_valid_o=0.
- Reads during CLEAR: the returned data is forced to 0 when the request is issued while busy_o=1.
- Read-during-write to the same address in the same cycle:
  - BYPASS=1: enabled bytes come from wr_data_i; the remaining bytes hold the old contents.
  - BYPASS=0: the old word is returned for all bytes.
- Read and write in the same cycle to different addresses are independent.
- Addresses wrap naturally modulo DEPTH; there is no range check.

Decomposition:
- Shared package (vera_mem_pkg): clear-FSM state encodings (ST_IDLE, ST_CLEAR) and the default DATA_W and BYTE_W.
- One sub-module, bram_be_1r1w: pure storage array with a byte-enabled write port and a registered read port, with no reset and no bypass.
- The FSM, bypass merge and latency pipeline stay in sprite_attr_mem.

Test Plan:
- Reset and init: defaults; assert then release rst_i.
  - busy_o=1 for exactly 256 cycles, clear_done_o pulses once, then busy_o=0.
  - Reading addresses 0, 128 and 255 returns 0x00000000.
- Byte enables:
  - Write 0xAABBCCDD to address 5 with ben=4'b1111, then 0x11223344 with ben=4'b0101.
  - Reading address 5 returns 0xAA22CC44, one cycle later when RD_LATENCY=1 and two cycles later when RD_LATENCY=2.
- Bypass: address 9 holds 0x12345678; in the same cycle write 0xFFFFFFFF with ben=4'b0011 and read address 9.
  - BYPASS=1 returns 0x1234FFFF.
  - BYPASS=0 returns 0x12345678.
  - A following read of address 9 returns 0x1234FFFF in both cases.
- Clear request:
  - After filling all 256 words with 0xDEADBEEF, pulse clear_req_i.
  - wr_ready_o=0 for 256 cycles; a write of 0x1 to address 3 mid-sweep is dropped.
  - A second clear_req_i mid-sweep does not extend the sweep.
  - Afterwards, address 3 reads 0.
- Reset mid-sweep: assert rst_i at sweep address 100, then release.
  - The sweep restarts at 0 and busy_o lasts a full 256 cycles.
  - Exactly one clear_done_o pulse is seen, from the restarted sweep.
- Streaming reads: issue rd_en_i on 10 consecutive cycles, addresses 0..9 holding value = address.
  - rd_valid_o is high for 10 consecutive cycles and the data sequence is 0..9 in order, with no gaps.
